// File: rtl/fifo_dac_spi_tx.sv
// FIFO drain to DAC SPI transmitter.
// Pops one 16-bit word at a time and shifts it out MSB-first under an
// active-low chip select. All outputs come straight from flops.
module fifo_dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        fifo_empty_i,
  input  logic [15:0] fifo_data_i,
  output logic        fifo_rd_en_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [15:0]   sreg, sreg_n;
  logic [DW-1:0] div_cnt, div_n;
  logic          half, half_n;   // 0: sclk-high half of a bit, 1: sclk-low half
  logic [3:0]    bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          start_ok;
  logic          rd_n, sclk_n, cs_n_n, mosi_n, busy_n, done_n;

  assign start_ok = enable_i & ~fifo_empty_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, counter and shift-register logic. Output flops are loaded
  // from the *next* state so each output lines up with the state it names.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    div_n   = div_cnt;
    half_n  = half;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    case (state)
      IDLE: if (start_ok) state_n = POP;
      POP:  state_n = LOAD;
      LOAD: begin
        sreg_n  = fifo_data_i;
        div_n   = '0;
        half_n  = 1'b0;
        bit_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              bit_n  = bit_cnt + 4'd1;
              sreg_n = {sreg[14:0], 1'b0};
            end
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = start_ok ? POP : IDLE;
        else                     gap_n   = gap_cnt + GW'(1);
      end
      default: state_n = IDLE;
    endcase
    rd_n   = (state_n == POP);
    cs_n_n = (state_n != SHIFT);
    sclk_n = !((state_n == SHIFT) && half_n);
    mosi_n = (state_n == SHIFT) && sreg_n[15];
    busy_n = (state_n != IDLE);
    done_n = (state == SHIFT) && (state_n == GAP);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg         <= '0;
      div_cnt      <= '0;
      half         <= 1'b0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      fifo_rd_en_o <= 1'b0;
      sclk_o       <= 1'b1;
      cs_n_o       <= 1'b1;
      mosi_o       <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      sreg         <= sreg_n;
      div_cnt      <= div_n;
      half         <= half_n;
      bit_cnt      <= bit_n;
      gap_cnt      <= gap_n;
      fifo_rd_en_o <= rd_n;
      sclk_o       <= sclk_n;
      cs_n_o       <= cs_n_n;
      mosi_o       <= mosi_n;
      busy_o       <= busy_n;
      frame_done_o <= done_n;
      if (done_n) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_dac_spi_tx.sv
// Bench for fifo_dac_spi_tx: three instances (CLK_DIV/CS_GAP = 2/2, 1/1, 5/1),
// each fed by a small FIFO model and checked against a frame-position model.
module tb_fifo_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en [3];
  logic        empty [3];
  logic [15:0] fdata [3] = '{16'h0, 16'h0, 16'h0};
  logic        rd [3], sclk [3], cs_n [3], mosi [3], busy [3], done [3];
  logic [15:0] fcnt [3];

  logic [15:0] mem [3][64];
  int          wp [3];
  int          rp [3] = '{0, 0, 0};

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: position inside the current frame (-1 = idle).
  int          pos [3];
  int          mp [3];
  logic [15:0] mw [3];
  logic [15:0] mcnt [3];

  // Observation of the serial stream.
  int          rdn [3], last_rd [3], lat [3], lowc [3], rxn [3], lastlen [3];
  logic [15:0] rxw [3], lastw [3];
  logic        prev_cs [3], prev_sclk [3];
  int          spmin, spmax, logn;
  logic [15:0] rxlog [32];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gdut
    fifo_dac_spi_tx #(
      .CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 5)),
      .CS_GAP (g == 0 ? 2 : 1)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (en[g]),
      .fifo_empty_i(empty[g]),
      .fifo_data_i (fdata[g]),
      .fifo_rd_en_o(rd[g]),
      .sclk_o      (sclk[g]),
      .cs_n_o      (cs_n[g]),
      .mosi_o      (mosi[g]),
      .busy_o      (busy[g]),
      .frame_done_o(done[g]),
      .frame_cnt_o (fcnt[g])
    );
  end

  // FIFO read side: registered data, valid the cycle after read_en.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        fdata[i] <= mem[i][rp[i] % 64];
        rp[i]    <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) empty[i] = (rp[i] >= wp[i]);
  end

  function automatic int divf(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
  endfunction

  function automatic int gapf(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got 0x%0h expected 0x%0h (cycle %0d)", i, nm, act, exp, cyc);
    end
  endtask

  task automatic push(int i, logic [15:0] v);
    mem[i][wp[i] % 64] = v;
    wp[i]++;
  endtask

  // Advance the model one clock using the inputs seen at the edge.
  task automatic model_step(int i);
    int d, p;
    d = divf(i);
    p = 2 + 32 * d + gapf(i);
    if (!rst_n) begin
      pos[i]  = -1;
      mcnt[i] = '0;
    end else begin
      if (pos[i] < 0 || pos[i] == p - 1) pos[i] = (en[i] && !empty[i]) ? 0 : -1;
      else                               pos[i]++;
      if (pos[i] == 0) begin
        mw[i] = mem[i][mp[i] % 64];
        mp[i]++;
      end
      if (pos[i] == 2 + 32 * d) mcnt[i]++;
    end
  endtask

  task automatic model_check(int i);
    int d, k;
    logic sh, e_sclk, e_mosi;
    d  = divf(i);
    k  = pos[i] - 2;
    sh = (k >= 0) && (k < 32 * d);
    e_sclk = 1'b1;
    e_mosi = 1'b0;
    if (sh) begin
      e_sclk = ((k % (2 * d)) < d);
      e_mosi = mw[i][15 - k / (2 * d)];
    end
    chk(i, "rd_en", rd[i], pos[i] == 0);
    chk(i, "busy", busy[i], pos[i] >= 0);
    chk(i, "cs_n", cs_n[i], !sh);
    chk(i, "sclk", sclk[i], e_sclk);
    chk(i, "mosi", mosi[i], e_mosi);
    chk(i, "frame_done", done[i], pos[i] == 2 + 32 * d);
    chk(i, "frame_cnt", fcnt[i], mcnt[i]);
  endtask

  task automatic track(int i);
    if (rd[i]) begin
      rdn[i]++;
      if (i == 0 && last_rd[0] >= 0) begin
        if (cyc - last_rd[0] < spmin) spmin = cyc - last_rd[0];
        if (cyc - last_rd[0] > spmax) spmax = cyc - last_rd[0];
      end
      last_rd[i] = cyc;
    end
    if (prev_cs[i] && !cs_n[i]) begin
      lat[i]  = cyc - last_rd[i];
      lowc[i] = 0;
      rxn[i]  = 0;
    end
    if (!cs_n[i]) lowc[i]++;
    if (prev_sclk[i] && !sclk[i] && !cs_n[i]) begin
      rxw[i] = {rxw[i][14:0], mosi[i]};
      rxn[i]++;
    end
    if (!prev_cs[i] && cs_n[i] && rxn[i] == 16) begin
      lastw[i]   = rxw[i];
      lastlen[i] = lowc[i];
      if (i == 0 && logn < 32) begin
        rxlog[logn] = rxw[i];
        logn++;
      end
    end
    prev_cs[i]   = cs_n[i];
    prev_sclk[i] = sclk[i];
  endtask

  task automatic wait_cnt(int i, int target, int budget);
    int k = 0;
    while (fcnt[i] != 16'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(i, "frame_cnt_wait", fcnt[i], target);
  endtask

  task automatic wait_rd(int target, int budget);
    int k = 0;
    while (rdn[0] != target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(0, "rd_count_wait", rdn[0], target);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;       wp[i] = 0;       pos[i] = -1;      mp[i] = 0;
      mcnt[i] = '0;       mw[i] = '0;      rdn[i] = 0;       last_rd[i] = -1;
      lat[i] = 0;         lowc[i] = 0;     rxn[i] = 0;       lastlen[i] = 0;
      rxw[i] = '0;        lastw[i] = '0;   prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1;
    end
    spmin = 1000000; spmax = 0; logn = 0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) begin
          model_check(i);
          track(i);
        end
      end
    join_none

    // Reset state, then idle with an empty FIFO.
    @(negedge clk);
    rst_n = 1'b1;
    chk(0, "rst_rd_en", rd[0], 0);
    chk(0, "rst_sclk", sclk[0], 1);
    chk(0, "rst_cs_n", cs_n[0], 1);
    chk(0, "rst_mosi", mosi[0], 0);
    chk(0, "rst_busy", busy[0], 0);
    chk(0, "rst_done", done[0], 0);
    chk(0, "rst_cnt", fcnt[0], 0);
    en[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk(0, "empty_no_read", rdn[0], 0);

    // Single word on all three divider settings.
    for (int i = 0; i < 3; i++) begin
      push(i, 16'hA5C3);
      en[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) wait_cnt(i, 1, 400);
    repeat (4) @(negedge clk);
    chk(0, "frame_len", lastlen[0], 64);
    chk(1, "frame_len", lastlen[1], 32);
    chk(2, "frame_len", lastlen[2], 160);
    for (int i = 0; i < 3; i++) begin
      chk(i, "single_payload", lastw[i], 16'hA5C3);
      chk(i, "single_pops", rdn[i], 1);
      chk(i, "pop_to_cs", lat[i], 2);
      chk(i, "single_idle", busy[i], 0);
      en[i] = (i == 0);
    end

    // Burst of 16 words.
    pulse_reset();
    rdn[0] = 0; last_rd[0] = -1; logn = 0;
    for (int k = 0; k < 16; k++) push(0, 16'(k));
    wait_cnt(0, 16, 16 * 68 + 100);
    repeat (60) @(negedge clk);
    chk(0, "burst_spacing_min", spmin, 68);
    chk(0, "burst_spacing_max", spmax, 68);
    chk(0, "burst_pops", rdn[0], 16);
    chk(0, "burst_frames", logn, 16);
    for (int k = 0; k < 16; k++) chk(0, "burst_payload", rxlog[k], k);
    chk(0, "burst_idle", busy[0], 0);

    // Enable dropped during bit 5 of frame 2.
    pulse_reset();
    rdn[0] = 0;
    push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333); push(0, 16'h4444);
    wait_rd(2, 300);
    repeat (23) @(negedge clk);
    en[0] = 1'b0;
    wait_cnt(0, 2, 200);
    repeat (60) @(negedge clk);
    chk(0, "drop_payload", lastw[0], 16'h2222);
    chk(0, "drop_pops", rdn[0], 2);
    chk(0, "drop_idle", busy[0], 0);
    en[0] = 1'b1;
    wait_cnt(0, 3, 200);
    repeat (2) @(negedge clk);
    chk(0, "resume_payload", lastw[0], 16'h3333);
    wait_cnt(0, 4, 200);
    repeat (2) @(negedge clk);
    chk(0, "resume_payload2", lastw[0], 16'h4444);

    // Reset during bit 8.
    push(0, 16'h5A5A); push(0, 16'h0F0F);
    wait_rd(5, 200);
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk(0, "midrst_cs_n", cs_n[0], 1);
    chk(0, "midrst_sclk", sclk[0], 1);
    chk(0, "midrst_cnt", fcnt[0], 0);
    chk(0, "midrst_busy", busy[0], 0);
    rst_n = 1'b1;
    wait_cnt(0, 1, 300);
    repeat (2) @(negedge clk);
    chk(0, "after_rst_payload", lastw[0], 16'h0F0F);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
